// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. Performs loads/stores over a req/ack
// data-memory handshake, resolves conditional branches, owns the condition
// register fed back to execute, and registers the writeback bundle.
// The execute latch keeps presenting a memory op while stall is high; the
// instruction behind it arrives after the ack edge and is accepted in IDLE.
module mem_stage #(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   alu_result,
    input  logic [31:0]   write_in,
    input  logic [3:0]    rd_in,
    input  logic [3:0]    branch_flags,
    input  logic [3:0]    br_cond,
    input  logic [31:0]   new_pc,
    input  logic [10:0]   signals,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_ack,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic          stall,
    output logic          take_branch,
    output logic [31:0]   branch_target,
    output logic [3:0]    alu_cond_out,
    output logic          wb_valid,
    output logic [31:0]   wb_data,
    output logic [3:0]    wb_rd,
    output logic          wb_reg_write
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          sig_mem_read;
    logic          sig_mem_write;
    logic          sig_reg_write;
    logic          sig_mem_to_reg;
    logic          sig_is_branch;
    logic          sig_set_cond;
    logic          mem_op;
    logic          br_hit;
    logic          accept;
    logic          access_done;

    logic [DW-1:0] hold_addr;
    logic [DW-1:0] hold_wdata;
    logic [RW-1:0] hold_rd;
    logic          hold_we;
    logic          hold_m2r;
    logic          hold_rw;

    // ALU op and imm controls belong to execute and are not used here
    logic          unused_ctrl;
    assign unused_ctrl = ^signals[4:0];

    // Control bundle decode and branch condition evaluation
    always_comb begin
        sig_mem_read   = signals[5];
        sig_mem_write  = signals[6];
        sig_reg_write  = signals[7];
        sig_mem_to_reg = signals[8];
        sig_is_branch  = signals[9];
        sig_set_cond   = signals[10];
        mem_op         = sig_mem_read | sig_mem_write;
        br_hit         = sig_is_branch &
                         ((br_cond == 4'hF) || ((br_cond & branch_flags) != 4'h0));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && mem_op) state_nxt = ACCESS;
            ACCESS:  if (dmem_ack)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs and stage-internal strobes decoded from state
    always_comb begin
        dmem_req    = 1'b0;
        stall       = 1'b0;
        accept      = 1'b0;
        access_done = 1'b0;
        case (state)
            IDLE: begin
                accept = in_valid;
            end
            ACCESS: begin
                dmem_req    = 1'b1;
                stall       = ~dmem_ack;
                access_done = dmem_ack;
            end
            default: ;
        endcase
    end

    // Request payload comes straight from the holding registers so it stays stable until ack
    always_comb begin
        dmem_addr  = AW'(hold_addr);
        dmem_we    = hold_we;
        dmem_wdata = hold_wdata;
    end

    // Holding registers for the in-flight memory op
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_rd    <= '0;
            hold_we    <= 1'b0;
            hold_m2r   <= 1'b0;
            hold_rw    <= 1'b0;
        end else if (accept && mem_op) begin
            hold_addr  <= alu_result;
            hold_wdata <= write_in;
            hold_rd    <= rd_in;
            hold_we    <= sig_mem_write;
            hold_m2r   <= sig_mem_to_reg;
            hold_rw    <= sig_reg_write & ~sig_mem_write;
        end
    end

    // Branch resolution and condition register
    always_ff @(posedge clk) begin
        if (rst) begin
            take_branch   <= 1'b0;
            branch_target <= '0;
            alu_cond_out  <= '0;
        end else begin
            take_branch <= accept & br_hit;
            if (accept && br_hit) branch_target <= new_pc;
            if (accept && sig_set_cond) alu_cond_out <= branch_flags;
        end
    end

    // Writeback latch; payload holds while invalid, write enable does not
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            if (accept && !mem_op) begin
                wb_valid     <= 1'b1;
                wb_data      <= alu_result;
                wb_rd        <= rd_in;
                wb_reg_write <= sig_reg_write;
            end else if (access_done) begin
                wb_valid     <= 1'b1;
                wb_data      <= (!hold_we && hold_m2r) ? dmem_rdata : hold_addr;
                wb_rd        <= hold_rd;
                wb_reg_write <= hold_rw;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a writeback scoreboard.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] write_in;
    logic [3:0]  rd_in;
    logic [3:0]  branch_flags;
    logic [3:0]  br_cond;
    logic [31:0] new_pc;
    logic [10:0] signals;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        stall;
    logic        take_branch;
    logic [31:0] branch_target;
    logic [3:0]  alu_cond_out;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_reg_write;

    localparam logic [10:0] S_MRD = 11'(1) << 5;
    localparam logic [10:0] S_MWR = 11'(1) << 6;
    localparam logic [10:0] S_RW  = 11'(1) << 7;
    localparam logic [10:0] S_M2R = 11'(1) << 8;
    localparam logic [10:0] S_BR  = 11'(1) << 9;
    localparam logic [10:0] S_SC  = 11'(1) << 10;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rd;
        logic        rw;
        logic        chk_data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    mem_stage #(.AW(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
        .write_in(write_in), .rd_in(rd_in), .branch_flags(branch_flags),
        .br_cond(br_cond), .new_pc(new_pc), .signals(signals),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .stall(stall), .take_branch(take_branch), .branch_target(branch_target),
        .alu_cond_out(alu_cond_out), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic wb_exp_t mk(input logic [31:0] d, input logic [3:0] r,
                                   input logic w, input logic c);
        wb_exp_t e;
        e.data = d; e.rd = r; e.rw = w; e.chk_data = c;
        return e;
    endfunction

    // Advance one clock and score any writeback produced on that edge
    task automatic tick();
        wb_exp_t e;
        @(posedge clk);
        #1;
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'(wb_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                if (e.chk_data) check("wb_data", wb_data, e.data);
                check("wb_rd", 32'(wb_rd), 32'(e.rd));
                check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
            end
        end else begin
            check("wb_rw_when_idle", 32'(wb_reg_write), 32'h0);
        end
    endtask

    // Issue one memory op; ack arrives on ACCESS cycle number waits+1
    task automatic mem_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] rd, input logic [10:0] sig,
                              input int waits, input logic [31:0] rdata,
                              input logic exp_we);
        in_valid = 1'b1; alu_result = addr; write_in = wdata; rd_in = rd; signals = sig;
        #1;
        check("stall_idle", 32'(stall), 32'h0);
        tick();
        for (int i = 0; i <= waits; i++) begin
            dmem_ack   = (i == waits);
            dmem_rdata = (i == waits) ? rdata : 32'h0;
            #1;
            check("dmem_req", 32'(dmem_req), 32'h1);
            check("dmem_addr", dmem_addr, addr);
            check("dmem_we", 32'(dmem_we), 32'(exp_we));
            if (exp_we) check("dmem_wdata", dmem_wdata, wdata);
            check("stall_access", 32'(stall), (i == waits) ? 32'h0 : 32'h1);
            if (i == waits) in_valid = 1'b0;
            tick();
        end
        dmem_ack = 1'b0;
        check("dmem_req_drop", 32'(dmem_req), 32'h0);
    endtask

    // Present one non-memory instruction for a single cycle
    task automatic alu_issue(input logic [31:0] res, input logic [3:0] rd,
                             input logic [10:0] sig, input logic [3:0] cond,
                             input logic [3:0] flags, input logic [31:0] pc);
        in_valid = 1'b1; alu_result = res; rd_in = rd; signals = sig;
        br_cond = cond; branch_flags = flags; new_pc = pc;
        sb.push_back(mk(res, rd, sig[7], 1'b1));
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; alu_result = '0; write_in = '0; rd_in = '0;
        branch_flags = '0; br_cond = '0; new_pc = '0; signals = '0;
        dmem_rdata = '0; dmem_ack = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_dmem_req", 32'(dmem_req), 32'h0);
        check("rst_dmem_we", 32'(dmem_we), 32'h0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        check("rst_dmem_wdata", dmem_wdata, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_take_branch", 32'(take_branch), 32'h0);
        check("rst_branch_target", branch_target, 32'h0);
        check("rst_alu_cond", 32'(alu_cond_out), 32'h0);
        check("rst_wb_valid", 32'(wb_valid), 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_rd", 32'(wb_rd), 32'h0);
        rst = 1'b0;
        tick();

        // ALU op: one-cycle writeback, no stall, payload holds afterwards
        alu_issue(32'h1234, 4'd3, S_RW, 4'h0, 4'h0, 32'h0);
        check("alu_wb_valid", 32'(wb_valid), 32'h1);
        check("alu_stall", 32'(stall), 32'h0);
        tick();
        check("alu_wb_valid_drop", 32'(wb_valid), 32'h0);
        check("alu_wb_data_hold", wb_data, 32'h1234);
        check("alu_wb_rd_hold", 32'(wb_rd), 32'h3);

        // Load with ack on the third ACCESS cycle
        sb.push_back(mk(32'hDEADBEEF, 4'd5, 1'b1, 1'b1));
        mem_access(32'h40, 32'h0, 4'd5, S_MRD | S_RW | S_M2R, 2, 32'hDEADBEEF, 1'b0);

        // Zero-wait store: register write suppressed
        sb.push_back(mk(32'h0, 4'd6, 1'b0, 1'b0));
        mem_access(32'h80, 32'hA5A5A5A5, 4'd6, S_MWR | S_RW, 0, 32'h0, 1'b1);

        // Read and write both set behaves as a store
        sb.push_back(mk(32'h0, 4'd7, 1'b0, 1'b0));
        mem_access(32'h84, 32'h5A5A0001, 4'd7, S_MRD | S_MWR | S_RW | S_M2R, 1, 32'h11, 1'b1);

        // Load without mem_to_reg writes back the address
        sb.push_back(mk(32'h44, 4'd8, 1'b1, 1'b1));
        mem_access(32'h44, 32'h0, 4'd8, S_MRD | S_RW, 1, 32'hCAFEF00D, 1'b0);

        // Branch taken on matching flag
        alu_issue(32'h0, 4'd0, S_BR, 4'b0100, 4'b0100, 32'h200);
        check("br_take", 32'(take_branch), 32'h1);
        check("br_target", branch_target, 32'h200);
        tick();
        check("br_pulse_end", 32'(take_branch), 32'h0);

        // Same branch with no flags: not taken
        alu_issue(32'h0, 4'd0, S_BR, 4'b0100, 4'b0000, 32'h300);
        check("br_not_taken", 32'(take_branch), 32'h0);

        // Always condition
        alu_issue(32'h0, 4'd0, S_BR, 4'hF, 4'h0, 32'h340);
        check("br_always", 32'(take_branch), 32'h1);
        check("br_always_target", branch_target, 32'h340);

        // Never condition even with all flags
        alu_issue(32'h0, 4'd0, S_BR, 4'h0, 4'hF, 32'h380);
        check("br_never", 32'(take_branch), 32'h0);

        // Matching condition without is_branch
        alu_issue(32'h0, 4'd0, S_RW, 4'hF, 4'hF, 32'h3C0);
        check("br_not_branch", 32'(take_branch), 32'h0);

        // Condition register load and hold
        alu_issue(32'h55, 4'd2, S_SC | S_RW, 4'h0, 4'b1001, 32'h0);
        check("cond_set", 32'(alu_cond_out), 32'h9);
        alu_issue(32'h66, 4'd2, S_RW, 4'h0, 4'b0110, 32'h0);
        check("cond_hold", 32'(alu_cond_out), 32'h9);

        // Reset asserted on the second ACCESS cycle abandons the load
        in_valid = 1'b1; alu_result = 32'h60; rd_in = 4'd9; signals = S_MRD | S_RW | S_M2R;
        tick();
        #1;
        check("abort_req_1", 32'(dmem_req), 32'h1);
        tick();
        #1;
        check("abort_req_2", 32'(dmem_req), 32'h1);
        rst = 1'b1;
        tick();
        check("abort_req_drop", 32'(dmem_req), 32'h0);
        check("abort_wb_valid", 32'(wb_valid), 32'h0);
        check("abort_stall", 32'(stall), 32'h0);
        rst = 1'b0; in_valid = 1'b0; signals = '0;
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        tick();
        check("late_ack_wb", 32'(wb_valid), 32'h0);
        check("late_ack_req", 32'(dmem_req), 32'h0);
        dmem_ack = 1'b0;
        tick();

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
